// File: rtl/ps2_key_controller.sv
// PS/2 keyboard receiver: pin synchronisation, 11-bit frame deframing with parity/stop checks,
// E0/F0 prefix folding into key events, and a small first-word-fall-through event FIFO.
module ps2_key_controller #(
  parameter int FIFO_AW        = 2,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  input  logic       iRead,
  output logic       oValid,
  output logic [7:0] oKeyCode,
  output logic       oBreak,
  output logic       oExtended,
  output logic       oParityErr,
  output logic       oFrameErr,
  output logic       oOverflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} frame_state_t;

  logic ps2_clk_s1_reg, ps2_clk_s2_reg, ps2_clk_prev_reg;
  logic ps2_data_s1_reg, ps2_data_s2_reg;
  logic fall_edge;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ps2_clk_s1_reg   <= 1'b0;
      ps2_clk_s2_reg   <= 1'b0;
      ps2_clk_prev_reg <= 1'b0;
      ps2_data_s1_reg  <= 1'b0;
      ps2_data_s2_reg  <= 1'b0;
    end else begin
      ps2_clk_s1_reg   <= PS2_CLK;
      ps2_clk_s2_reg   <= ps2_clk_s1_reg;
      ps2_clk_prev_reg <= ps2_clk_s2_reg;
      ps2_data_s1_reg  <= PS2_DATA;
      ps2_data_s2_reg  <= ps2_data_s1_reg;
    end
  end

  assign fall_edge = ps2_clk_prev_reg & ~ps2_clk_s2_reg;

  frame_state_t   state_reg, state_next;
  logic [2:0]     bit_cnt_reg, bit_cnt_next;
  logic [7:0]     shift_reg, shift_next;
  logic           parity_bit_reg, parity_bit_next;
  logic [TW-1:0]  timeout_cnt_reg, timeout_cnt_next;
  logic           byte_strobe_reg, byte_strobe_next;
  logic           parity_err_reg, parity_err_next;
  logic           frame_err_reg, frame_err_next;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg       <= S_IDLE;
      bit_cnt_reg     <= 3'd0;
      shift_reg       <= 8'h00;
      parity_bit_reg  <= 1'b0;
      timeout_cnt_reg <= '0;
      byte_strobe_reg <= 1'b0;
      parity_err_reg  <= 1'b0;
      frame_err_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      shift_reg       <= shift_next;
      parity_bit_reg  <= parity_bit_next;
      timeout_cnt_reg <= timeout_cnt_next;
      byte_strobe_reg <= byte_strobe_next;
      parity_err_reg  <= parity_err_next;
      frame_err_reg   <= frame_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    shift_next       = shift_reg;
    parity_bit_next  = parity_bit_reg;
    timeout_cnt_next = timeout_cnt_reg;
    byte_strobe_next = 1'b0;
    parity_err_next  = 1'b0;
    frame_err_next   = 1'b0;

    // Watchdog only runs while a frame is in progress and no edge arrives
    if (state_reg == S_IDLE || fall_edge) begin
      timeout_cnt_next = '0;
    end else if (timeout_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
      timeout_cnt_next = '0;
      state_next       = S_IDLE;
      frame_err_next   = 1'b1;
    end else begin
      timeout_cnt_next = timeout_cnt_reg + 1'b1;
    end

    if (fall_edge) begin
      case (state_reg)
        S_IDLE: begin
          if (!ps2_data_s2_reg) begin
            state_next   = S_DATA;
            bit_cnt_next = 3'd0;
          end
        end
        S_DATA: begin
          shift_next   = {ps2_data_s2_reg, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) state_next = S_PARITY;
        end
        S_PARITY: begin
          parity_bit_next = ps2_data_s2_reg;
          state_next      = S_STOP;
        end
        S_STOP: begin
          if (!(^{shift_reg, parity_bit_reg})) parity_err_next = 1'b1;
          else if (!ps2_data_s2_reg)           frame_err_next  = 1'b1;
          else                                 byte_strobe_next = 1'b1;
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  logic       ext_pend_reg, break_pend_reg;
  logic       is_prefix;
  logic       push;
  logic [9:0] push_data;

  assign is_prefix = (shift_reg == 8'hE0) || (shift_reg == 8'hF0);
  assign push      = byte_strobe_reg & ~is_prefix;
  assign push_data = {ext_pend_reg, break_pend_reg, shift_reg};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ext_pend_reg   <= 1'b0;
      break_pend_reg <= 1'b0;
    end else if (parity_err_reg || frame_err_reg) begin
      ext_pend_reg   <= 1'b0;
      break_pend_reg <= 1'b0;
    end else if (byte_strobe_reg) begin
      if (shift_reg == 8'hE0) begin
        ext_pend_reg <= 1'b1;
      end else if (shift_reg == 8'hF0) begin
        break_pend_reg <= 1'b1;
      end else begin
        ext_pend_reg   <= 1'b0;
        break_pend_reg <= 1'b0;
      end
    end
  end

  logic [9:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_AW:0]   count_reg;
  logic               overflow_reg;
  logic               empty, full, pop, wr_en, drop;
  logic [9:0]         head;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (FIFO_AW + 1)'(DEPTH));
  assign pop   = iRead & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge Clock) begin
    if (wr_en) fifo_mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (drop) overflow_reg <= 1'b1;
    end
  end

  assign head       = fifo_mem[rd_ptr_reg];
  assign oValid     = ~empty;
  assign oKeyCode   = oValid ? head[7:0] : 8'h00;
  assign oBreak     = oValid & head[8];
  assign oExtended  = oValid & head[9];
  assign oParityErr = parity_err_reg;
  assign oFrameErr  = frame_err_reg;
  assign oOverflow  = overflow_reg;

endmodule

// File: tb/tb_ps2_key_controller.sv
// Directed bench for ps2_key_controller: table of frames with expected events plus
// hand-written sequences for latency, overflow, timeout and mid-frame reset.
module tb_ps2_key_controller;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic       iRead;
  logic       oValid;
  logic [7:0] oKeyCode;
  logic       oBreak;
  logic       oExtended;
  logic       oParityErr;
  logic       oFrameErr;
  logic       oOverflow;

  int checks = 0;
  int errors = 0;
  int perr_seen = 0;
  int ferr_seen = 0;
  logic valid_at3, valid_at4;

  ps2_key_controller #(.FIFO_AW(2), .TIMEOUT_CYCLES(2000)) dut (
    .Clock(Clock), .Reset(Reset), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA), .iRead(iRead),
    .oValid(oValid), .oKeyCode(oKeyCode), .oBreak(oBreak), .oExtended(oExtended),
    .oParityErr(oParityErr), .oFrameErr(oFrameErr), .oOverflow(oOverflow)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (oParityErr) perr_seen++;
    if (oFrameErr)  ferr_seen++;
  end

  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_key;
    logic       exp_brk;
    logic       exp_ext;
    int         exp_perr;
    int         exp_ferr;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge Clock);
    PS2_DATA = b;
    repeat (4) @(negedge Clock);
    PS2_CLK = 1'b0;
    repeat (8) @(negedge Clock);
    PS2_CLK = 1'b1;
    repeat (8) @(negedge Clock);
  endtask

  // Stop bit is driven by hand so the write cycle (4 cycles after the low drive) is known
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop,
                            input logic pop_on_write);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(~(^d) ^ bad_par);
    @(negedge Clock);
    PS2_DATA = stop;
    repeat (4) @(negedge Clock);
    PS2_CLK = 1'b0;
    repeat (3) @(negedge Clock);
    valid_at3 = oValid;
    if (pop_on_write) iRead = 1'b1;
    @(negedge Clock);
    iRead = 1'b0;
    valid_at4 = oValid;
    repeat (4) @(negedge Clock);
    PS2_CLK = 1'b1;
    repeat (8) @(negedge Clock);
  endtask

  task automatic pop_one;
    @(negedge Clock);
    iRead = 1'b1;
    @(negedge Clock);
    iRead = 1'b0;
  endtask

  initial begin
    int first;
    logic [7:0] ov_codes [4];

    vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b0, 0, 0};
    vecs[1]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0};
    vecs[2]  = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b1, 1'b0, 0, 0};
    vecs[3]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0};
    vecs[4]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0};
    vecs[5]  = '{8'h75, 1'b0, 1'b1, 1'b1, 8'h75, 1'b1, 1'b1, 0, 0};
    vecs[6]  = '{8'h1C, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1, 0};
    vecs[7]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0};
    vecs[8]  = '{8'h1C, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1, 0};
    vecs[9]  = '{8'h75, 1'b0, 1'b1, 1'b1, 8'h75, 1'b0, 1'b0, 0, 0};
    vecs[10] = '{8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1};
    vecs[11] = '{8'hE0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0};
    vecs[12] = '{8'h6B, 1'b0, 1'b1, 1'b1, 8'h6B, 1'b0, 1'b1, 0, 0};
    vecs[13] = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0};
    vecs[14] = '{8'h4D, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 0};
    vecs[15] = '{8'h4D, 1'b0, 1'b1, 1'b1, 8'h4D, 1'b0, 1'b0, 0, 0};
    vecs[16] = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0};
    vecs[17] = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1};
    vecs[18] = '{8'h2A, 1'b0, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b0, 0, 0};

    Reset = 1'b1; PS2_CLK = 1'b1; PS2_DATA = 1'b1; iRead = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst_valid", oValid, 0);
    check("rst_key", oKeyCode, 0);
    check("rst_perr", oParityErr, 0);
    check("rst_ferr", oFrameErr, 0);
    check("rst_ovf", oOverflow, 0);
    Reset = 1'b0;
    repeat (5) @(negedge Clock);

    // Exact latency of the first event
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("lat_valid_n1", valid_at3, 0);
    check("lat_valid_n2", valid_at4, 1);
    check("lat_key", oKeyCode, 8'h1C);
    check("lat_brk", oBreak, 0);
    check("lat_ext", oExtended, 0);
    pop_one();
    check("lat_pop_valid", oValid, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge Clock);
      perr_seen = 0;
      ferr_seen = 0;
      send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].stop, 1'b0);
      $display("row %0d code %02h valid %0d key %02h brk %0d ext %0d perr %0d ferr %0d",
               i, vecs[i].code, oValid, oKeyCode, oBreak, oExtended, perr_seen, ferr_seen);
      check($sformatf("row%0d_perr", i), perr_seen, vecs[i].exp_perr);
      check($sformatf("row%0d_ferr", i), ferr_seen, vecs[i].exp_ferr);
      check($sformatf("row%0d_valid", i), oValid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check($sformatf("row%0d_key", i), oKeyCode, vecs[i].exp_key);
        check($sformatf("row%0d_brk", i), oBreak, vecs[i].exp_brk);
        check($sformatf("row%0d_ext", i), oExtended, vecs[i].exp_ext);
        pop_one();
        check($sformatf("row%0d_empty", i), oValid, 0);
      end
    end

    // Push and pop in the same cycle while full: no overflow
    ov_codes[0] = 8'h16; ov_codes[1] = 8'h1E; ov_codes[2] = 8'h26; ov_codes[3] = 8'h25;
    for (int i = 0; i < 4; i++) send_frame(ov_codes[i], 1'b0, 1'b1, 1'b0);
    send_frame(8'h2E, 1'b0, 1'b1, 1'b1);
    check("pp_ovf", oOverflow, 0);
    for (int i = 1; i < 4; i++) begin
      check($sformatf("pp_key%0d", i), oKeyCode, ov_codes[i]);
      pop_one();
    end
    check("pp_key_last", oKeyCode, 8'h2E);
    pop_one();
    check("pp_empty", oValid, 0);

    // Overflow: five events into a four-entry FIFO
    for (int i = 0; i < 4; i++) send_frame(ov_codes[i], 1'b0, 1'b1, 1'b0);
    check("ov_before", oOverflow, 0);
    send_frame(8'h2E, 1'b0, 1'b1, 1'b0);
    check("ov_set", oOverflow, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ov_valid%0d", i), oValid, 1);
      check($sformatf("ov_key%0d", i), oKeyCode, ov_codes[i]);
      pop_one();
    end
    check("ov_empty", oValid, 0);
    check("ov_sticky", oOverflow, 1);

    // Timeout after start bit + 3 data bits
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    perr_seen = 0;
    ferr_seen = 0;
    first = -1;
    for (int i = 1; i <= 2100; i++) begin
      @(negedge Clock);
      if (oFrameErr && first < 0) first = i;
    end
    $display("timeout pulse at cycle %0d, pulses %0d", first, ferr_seen);
    check("to_pulses", ferr_seen, 1);
    check("to_window", (first >= 1980 && first <= 1995), 1);
    check("to_valid", oValid, 0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("to_after_valid", oValid, 1);
    check("to_after_key", oKeyCode, 8'h1C);

    // Reset mid-frame with an entry still queued
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    @(negedge Clock);
    perr_seen = 0;
    ferr_seen = 0;
    Reset = 1'b1;
    @(negedge Clock);
    check("mr_valid", oValid, 0);
    check("mr_key", oKeyCode, 0);
    check("mr_ovf", oOverflow, 0);
    check("mr_brk_ext", {oBreak, oExtended}, 0);
    Reset = 1'b0;
    repeat (10) @(negedge Clock);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    check("mr_no_err", perr_seen + ferr_seen, 0);
    check("mr_valid_after", oValid, 1);
    check("mr_key_after", oKeyCode, 8'h29);
    pop_one();
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    check("mr_stop0_ferr", ferr_seen, 1);
    check("mr_stop0_valid", oValid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_controller.md
Name: ps2_key_controller

Overview:
Receives and sequences PS/2 keyboard traffic for the MiniAlu/VGA system. It synchronises the PS2_CLK/PS2_DATA pins, deframes 11-bit PS/2 frames and checks parity and stop bits. It folds E0 (extended) and F0 (break) prefixes into single key events and buffers those events in a small FIFO that the MiniAlu/VGA logic drains with a pop strobe.

Parameters:
FIFO_AW, 2, log2 of FIFO depth (default 4 entries of 10 bits)
TIMEOUT_CYCLES, 2000, Clock cycles with no PS2_CLK falling edge before a partial frame is abandoned

Ports:
Clock  input  1  system clock; all state on rising edge
Reset  input  1  synchronous, active-high reset
PS2_CLK  input  1  raw keyboard clock pin, asynchronous
PS2_DATA  input  1  raw keyboard data pin, asynchronous
iRead  input  1  pop strobe for FIFO head; ignored when oValid=0
oValid  output  1  FIFO non-empty; head fields valid
oKeyCode  output  8  head scan code (prefix bytes stripped)
oBreak  output  1  head event was preceded by F0 (key release)
oExtended  output  1  head event was preceded by E0
oParityErr  output  1  one-cycle pulse: frame discarded on bad parity
oFrameErr  output  1  one-cycle pulse: stop bit = 0 or timeout mid-frame
oOverflow  output  1  sticky: an event was dropped because FIFO full; cleared only by Reset

Behaviour:
- Reset: Clock-synchronous, active-high. All outputs 0. FIFO empty, frame FSM IDLE, prefix flags clear, synchronisers and timeout counter cleared. Reset mid-frame discards the partial frame with no error pulse.
- Sync: PS2_CLK and PS2_DATA each pass through 2 flops. The falling edge is detected when the previous synced clock = 1 and the current synced clock = 0. Data is sampled from the synced PS2_DATA in the same cycle.
- Frame FSM, advancing only on falling edges:
  - IDLE: data=0 -> DATA, bit count=0. data=1 -> stay in IDLE (glitch ignored).
  - DATA: shift in LSB first. After the 8th bit -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: odd parity over 8 data bits + parity bit required.
    - Parity bad -> oParityErr pulse, no byte produced.
    - Parity ok and stop=0 -> oFrameErr pulse, no byte.
    - Parity ok and stop=1 -> byte strobe.
    - All three cases -> IDLE. Parity error takes precedence if both parity and stop are bad.
- Timeout: counter clears on every falling edge and in IDLE. In any state other than IDLE, reaching TIMEOUT_CYCLES -> IDLE and one oFrameErr pulse.
- Assembler, on byte strobe:
  - E0 sets ext_pend.
  - F0 sets break_pend.
  - Any other byte pushes {ext_pend, break_pend, byte} into the FIFO and clears both flags.
  - Any parity/frame error also clears both flags.
- Latency: byte strobe is registered one cycle after the stop-bit edge detect cycle N. FIFO write happens at the end of N+1. oValid/head fields are visible at N+2.
- FIFO, first-word-fall-through:
  - Head fields are driven from the read pointer. Pointers wrap modulo 2^FIFO_AW, with a count of FIFO_AW+1 bits.
  - iRead with oValid=1 pops at the clock edge.
  - Push when full with no pop: event dropped, oOverflow set, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Push with iRead while empty: push occurs, iRead ignored.
  - Head fields are held stable while oValid=1 and no pop occurs.

Test Plan:
1. Frame bits 0, 0,0,1,1,1,0,0,0, parity 0, stop 1 (0x1C, 3 ones) -> oValid high 2 cycles after the stop edge; oKeyCode=0x1C, oBreak=0, oExtended=0. iRead for one cycle -> oValid=0.
2. Frames F0 then 1C -> exactly one FIFO entry: 0x1C, oBreak=1, oExtended=0. Frames E0, F0, 75 -> one entry: 0x75, oBreak=1, oExtended=1.
3. 0x1C sent with parity bit 1 -> single-cycle oParityErr, oValid stays 0. Then E0 + bad-parity frame + 0x75 -> 0x75 with oExtended=0 (prefix flushed by the error).
4. Codes 0x16, 0x1E, 0x26, 0x25, 0x2E with no reads (depth 4) -> oOverflow=1. Reads return 0x16, 0x1E, 0x26, 0x25 in order, then oValid=0. oOverflow stays 1 until Reset.
5. Start bit + 3 data bits, then PS2_CLK held high for 2100 cycles -> one oFrameErr pulse ~2000 cycles after the last edge. A following full 0x1C frame is received correctly.
6. Reset asserted for one cycle mid-frame (after bit 5) -> all outputs 0. The next complete 0x29 frame yields oKeyCode=0x29. A stop bit of 0 in a later frame -> oFrameErr pulse, no entry.
